add_pipe: RTL and testbench

Parametrised, carry-segmented pipelined adder/subtractor with valid/ready handshaking. It is the next generation of the single-mode 64-bit registered adder. It adds a subtract mode, carry and signed-overflow flags, and configurable width and pipeline depth, and it adds backpressure. It sits between an issue stage (request side) and a writeback/consumer stage (response side), sustaining one operation per cycle.

---
 rtl/add_pipe.sv | 115 +++++++++++
 tb/tb_add_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
// add_pipe: carry-segmented pipelined adder/subtractor, SEGS carry slices of WIDTH/SEGS bits.
// Latency: exactly SEGS cycles from accepted request to resp_valid; one op per cycle sustained.
// Backpressure: whole pipeline freezes while resp_valid && !resp_ready; req_ready = !resp_valid || resp_ready.
//
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake; req_sub selects x-y, req_in_1/req_in_2 are x/y
//   resp_valid/resp_ready- response handshake
//   resp_result          - x +/- y modulo 2^WIDTH
//   resp_carry           - carry out of the MSB (for subtract, 1 = no borrow)
//   resp_overflow        - two's-complement signed overflow
module add_pipe #(
  parameter int WIDTH = 64,
  parameter int SEGS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [WIDTH-1:0] req_in_1,
  input  logic [WIDTH-1:0] req_in_2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_overflow
);

  localparam int SEG = WIDTH / SEGS;

  logic             advance;
  logic [WIDTH-1:0] y_eff;

  // Subtract is x + ~y + 1; the +1 enters as the carry into the lowest slice.
  assign y_eff = req_sub ? ~req_in_2 : req_in_2;

  for (genvar k = 0; k < SEGS; k++) begin : g_stg
    // Operand bits not yet consumed when this stage runs (its own slice is the bottom SEG bits).
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0]          xs;
    logic [RW-1:0]          ys;
    logic                   ci;
    logic                   vi;
    logic [SEG:0]           add;
    logic [(k+1)*SEG-1:0]   sn;
    logic [(k+1)*SEG-1:0]   sum;
    logic                   vld;
    logic                   co;

    if (k == 0) begin : g_first
      assign xs = req_in_1;
      assign ys = y_eff;
      assign ci = req_sub;
      assign vi = req_valid;
      assign sn = add[SEG-1:0];
    end else begin : g_next
      assign xs = g_stg[k-1].g_hold.xr;
      assign ys = g_stg[k-1].g_hold.yr;
      assign ci = g_stg[k-1].co;
      assign vi = g_stg[k-1].vld;
      assign sn = {add[SEG-1:0], g_stg[k-1].sum};
    end

    assign add = {1'b0, xs[SEG-1:0]} + {1'b0, ys[SEG-1:0]} + {{SEG{1'b0}}, ci};

    // Valid, partial sum and carry are reset so the final stage presents zeros after reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= 1'b0;
        sum <= '0;
        co  <= 1'b0;
      end else if (advance) begin
        vld <= vi;
        sum <= sn;
        co  <= add[SEG];
      end
    end

    if (k < SEGS - 1) begin : g_hold
      // Upper operand slices ride along unchanged; their content is meaningless without vld.
      logic [RW-SEG-1:0] xr;
      logic [RW-SEG-1:0] yr;

      always_ff @(posedge clk) begin
        if (advance) begin
          xr <= xs[RW-1:SEG];
          yr <= ys[RW-1:SEG];
        end
      end
    end else begin : g_last
      logic ov;

      // Same-signed operands producing a differently-signed result means signed overflow.
      always_ff @(posedge clk) begin
        if (reset) begin
          ov <= 1'b0;
        end else if (advance) begin
          ov <= (xs[SEG-1] == ys[SEG-1]) && (add[SEG-1] != xs[SEG-1]);
        end
      end
    end
  end

  assign resp_valid    = g_stg[SEGS-1].vld;
  assign resp_result   = g_stg[SEGS-1].sum;
  assign resp_carry    = g_stg[SEGS-1].co;
  assign resp_overflow = g_stg[SEGS-1].g_last.ov;

  // The pipeline moves as a whole; bubbles are not squeezed out.
  assign advance   = !resp_valid || resp_ready;
  assign req_ready = advance;

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_sub;
  logic [63:0] req_in_1;
  logic [63:0] req_in_2;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;
  logic        resp_carry;
  logic        resp_overflow;

  int vecs = 0;
  int errs = 0;

  add_pipe #(.WIDTH(64), .SEGS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sub       (req_sub),
    .req_in_1      (req_in_1),
    .req_in_2      (req_in_2),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_carry    (resp_carry),
    .resp_overflow (resp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then waits (bounded) for its response; lat = edges until resp_valid.
  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic sub, output int lat);
    req_valid  = 1'b1;
    req_in_1   = x;
    req_in_2   = y;
    req_sub    = sub;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    vecs++; if (resp_result !== 64'd0) begin errs++; $display("FAIL reset_result: got %h want 0", resp_result); end
    vecs++; if ({resp_carry, resp_overflow} !== 2'b00) begin errs++; $display("FAIL reset_flags: got %b want 00", {resp_carry, resp_overflow}); end
    reset = 1'b0;
    #1;
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_carry_boundary();
    int lat;
    issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL carry_latency: got %0d want 2", lat); end
    vecs++; if (resp_result !== 64'h0000_0001_0000_0000) begin errs++; $display("FAIL carry_result: got %h want 0000000100000000", resp_result); end
    vecs++; if (resp_carry !== 1'b0) begin errs++; $display("FAIL carry_carry: got %b want 0", resp_carry); end
    vecs++; if (resp_overflow !== 1'b0) begin errs++; $display("FAIL carry_ovf: got %b want 0", resp_overflow); end
  endtask

  task automatic test_sub_wrap();
    int lat;
    issue(64'd0, 64'd1, 1'b1, lat);
    vecs++; if (resp_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errs++; $display("FAIL sub_wrap_result: got %h want ffffffffffffffff", resp_result); end
    vecs++; if (resp_carry !== 1'b0) begin errs++; $display("FAIL sub_wrap_carry: got %b want 0", resp_carry); end
    vecs++; if (resp_overflow !== 1'b0) begin errs++; $display("FAIL sub_wrap_ovf: got %b want 0", resp_overflow); end
    issue(64'd5, 64'd3, 1'b1, lat);
    vecs++; if (resp_result !== 64'd2) begin errs++; $display("FAIL sub_5_3_result: got %h want 2", resp_result); end
    vecs++; if (resp_carry !== 1'b1) begin errs++; $display("FAIL sub_5_3_carry: got %b want 1", resp_carry); end
  endtask

  task automatic test_overflow();
    int lat;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    vecs++; if (resp_result !== 64'h8000_0000_0000_0000) begin errs++; $display("FAIL ovf_add_result: got %h want 8000000000000000", resp_result); end
    vecs++; if (resp_overflow !== 1'b1) begin errs++; $display("FAIL ovf_add_ovf: got %b want 1", resp_overflow); end
    vecs++; if (resp_carry !== 1'b0) begin errs++; $display("FAIL ovf_add_carry: got %b want 0", resp_carry); end
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, lat);
    vecs++; if (resp_result !== 64'h7FFF_FFFF_FFFF_FFFF) begin errs++; $display("FAIL ovf_sub_result: got %h want 7fffffffffffffff", resp_result); end
    vecs++; if (resp_overflow !== 1'b1) begin errs++; $display("FAIL ovf_sub_ovf: got %b want 1", resp_overflow); end
    vecs++; if (resp_carry !== 1'b1) begin errs++; $display("FAIL ovf_sub_carry: got %b want 1", resp_carry); end
  endtask

  // Six adds i+i streamed back to back; consumer stalls in cycles 3..5.
  // Ops 1,2 enter in cycles 1,2; op1 waits at the output through the stall,
  // so pops land in cycles 6..11 with results 2,4,...,12.
  task automatic test_back_to_back();
    int nxt;
    int npop;
    logic exp_rdy;
    // drain whatever is left from earlier tests
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    step();
    nxt  = 1;
    npop = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      resp_ready = !(cyc >= 3 && cyc <= 5);
      req_valid  = (nxt <= 6);
      req_sub    = 1'b0;
      req_in_1   = 64'(nxt);
      req_in_2   = 64'(nxt);
      #1;
      exp_rdy = !(cyc >= 3 && cyc <= 5);
      vecs++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL bp_req_ready cyc %0d: got %b want %b", cyc, req_ready, exp_rdy); end
      if (cyc >= 3 && cyc <= 5) begin
        vecs++; if (resp_valid !== 1'b1 || resp_result !== 64'd2) begin errs++; $display("FAIL bp_hold cyc %0d: got v=%b r=%h want v=1 r=2", cyc, resp_valid, resp_result); end
      end
      if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
        vecs++; if (resp_result !== 64'(2 * (npop + 1))) begin errs++; $display("FAIL bp_result pop %0d: got %h want %h", npop, resp_result, 64'(2 * (npop + 1))); end
        vecs++; if (cyc !== 6 + npop) begin errs++; $display("FAIL bp_pop_cycle pop %0d: got %0d want %0d", npop, cyc, 6 + npop); end
        npop++;
      end
      if (req_valid === 1'b1 && req_ready === 1'b1) nxt++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    vecs++; if (npop !== 6) begin errs++; $display("FAIL bp_pop_count: got %0d want 6", npop); end
    vecs++; if (nxt !== 7) begin errs++; $display("FAIL bp_accept_count: got %0d want 6", nxt - 1); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    int seen;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    step();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_sub    = 1'b0;
    req_in_1   = 64'd3;
    req_in_2   = 64'd4;
    step();
    req_in_1 = 64'd5;
    req_in_2 = 64'd6;
    step();
    // request presented during reset must be dropped as well
    reset    = 1'b1;
    req_in_1 = 64'd100;
    req_in_2 = 64'd100;
    step();
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    vecs++; if (resp_result !== 64'd0) begin errs++; $display("FAIL midrst_result: got %h want 0", resp_result); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b0) seen++;
      step();
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen); end
    issue(64'd7, 64'd8, 1'b0, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL midrst_latency: got %0d want 2", lat); end
    vecs++; if (resp_result !== 64'd15) begin errs++; $display("FAIL midrst_result_15: got %h want f", resp_result); end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_sub    = 1'b0;
    req_in_1   = 64'd0;
    req_in_2   = 64'd0;
    resp_ready = 1'b0;
    #1;
    test_reset();
    test_carry_boundary();
    test_sub_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
